// File: rtl/membus_axi_arbiter.sv
// membus_axi_arbiter
//   Round-robin arbiter that funnels NPORT membus requesters onto a single
//   AXI4 master. Each accepted request becomes one single-beat AXI read or
//   write with dram_base added to the address. Only one transaction is ever
//   outstanding. AXI error responses are recorded sticky per requester.
// Ports
//   clk, rst         clock, synchronous active-high reset
//   dram_base        offset added to every membus address
//   mem_*            NPORT membus requester ports (flat, port i at slice i)
//   mem_rvalid/rdata one-cycle completion pulse to the owning port, shared data
//   M_AXI_*          AXI4 master (AW/W/B/AR/R)
//   axi_err          sticky per-port RRESP/BRESP != OKAY flag
//   busy             transaction in flight
module membus_axi_arbiter #(
  parameter int NPORT      = 2,
  parameter int AXI_ID_W   = 1,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [AXI_ADDR_W-1:0]         dram_base,
  input  logic [NPORT-1:0]              mem_valid,
  output logic [NPORT-1:0]              mem_ready,
  input  logic [NPORT*AXI_ADDR_W-1:0]   mem_addr,
  input  logic [NPORT-1:0]              mem_wen,
  input  logic [NPORT*AXI_DATA_W-1:0]   mem_wdata,
  input  logic [NPORT*AXI_DATA_W/8-1:0] mem_wmask,
  output logic [NPORT-1:0]              mem_rvalid,
  output logic [AXI_DATA_W-1:0]         mem_rdata,
  // AW
  output logic [AXI_ID_W-1:0]           M_AXI_AWID,
  output logic [AXI_ADDR_W-1:0]         M_AXI_AWADDR,
  output logic [7:0]                    M_AXI_AWLEN,
  output logic [2:0]                    M_AXI_AWSIZE,
  output logic [1:0]                    M_AXI_AWBURST,
  output logic                          M_AXI_AWLOCK,
  output logic [3:0]                    M_AXI_AWCACHE,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic [3:0]                    M_AXI_AWQOS,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  // W
  output logic [AXI_DATA_W-1:0]         M_AXI_WDATA,
  output logic [AXI_DATA_W/8-1:0]       M_AXI_WSTRB,
  output logic                          M_AXI_WLAST,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  // B
  input  logic [AXI_ID_W-1:0]           M_AXI_BID,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  // AR
  output logic [AXI_ID_W-1:0]           M_AXI_ARID,
  output logic [AXI_ADDR_W-1:0]         M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic                          M_AXI_ARLOCK,
  output logic [3:0]                    M_AXI_ARCACHE,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic [3:0]                    M_AXI_ARQOS,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  // R
  input  logic [AXI_ID_W-1:0]           M_AXI_RID,
  input  logic [AXI_DATA_W-1:0]         M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  // status
  output logic [NPORT-1:0]              axi_err,
  output logic                          busy
);

  localparam int SW   = AXI_DATA_W / 8;
  localparam int PW   = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int SIZE = $clog2(SW);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B, S_RESP} state_t;

  state_t                r_state;
  logic [PW-1:0]         r_rr_ptr;
  logic [PW-1:0]         r_owner;
  logic [AXI_ID_W-1:0]   r_id;
  logic [AXI_ADDR_W-1:0] r_addr;
  logic [AXI_DATA_W-1:0] r_wdata;
  logic [SW-1:0]         r_wmask;
  logic [AXI_DATA_W-1:0] r_rdata;
  logic [NPORT-1:0]      r_rvalid;
  logic [NPORT-1:0]      r_err;
  logic                  r_arvalid, r_awvalid, r_wvalid, r_rready, r_bready;

  // Arbitration: first valid port at or after rr_ptr, wrapping.
  logic [NPORT-1:0]      w_grant;
  logic [PW-1:0]         w_gidx;
  logic [PW-1:0]         w_scan;
  logic                  w_gvld;
  int                    w_idx;

  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_gvld  = 1'b0;
    w_idx   = 0;
    w_scan  = '0;
    for (int k = 0; k < NPORT; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NPORT) w_idx = w_idx - NPORT;
      w_scan = PW'(w_idx);
      if (!w_gvld && mem_valid[w_scan]) begin
        w_gvld = 1'b1;
        w_gidx = w_scan;
      end
    end
    if (w_gvld && (r_state == S_IDLE)) w_grant[w_gidx] = 1'b1;
  end

  logic [AXI_ADDR_W-1:0] w_sel_addr;
  logic [AXI_DATA_W-1:0] w_sel_wdata;
  logic [SW-1:0]         w_sel_wmask;
  logic                  w_sel_wen;
  logic [PW-1:0]         w_rr_next;
  logic                  w_aw_done, w_w_done;

  assign w_sel_addr  = mem_addr[w_gidx*AXI_ADDR_W +: AXI_ADDR_W];
  assign w_sel_wdata = mem_wdata[w_gidx*AXI_DATA_W +: AXI_DATA_W];
  assign w_sel_wmask = mem_wmask[w_gidx*SW +: SW];
  assign w_sel_wen   = mem_wen[w_gidx];
  assign w_rr_next   = (w_gidx == PW'(NPORT-1)) ? '0 : w_gidx + 1'b1;
  // A channel counts as done once its handshake already happened or happens now.
  assign w_aw_done   = !r_awvalid || M_AXI_AWREADY;
  assign w_w_done    = !r_wvalid  || M_AXI_WREADY;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_owner   <= '0;
      r_id      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wmask   <= '0;
      r_rdata   <= '0;
      r_rvalid  <= '0;
      r_err     <= '0;
      r_arvalid <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_rready  <= 1'b0;
      r_bready  <= 1'b0;
    end else begin
      r_rvalid <= '0;  // completion is a single-cycle pulse
      case (r_state)
        S_IDLE: if (w_gvld) begin
          r_owner  <= w_gidx;
          r_id     <= AXI_ID_W'(w_gidx);
          r_addr   <= dram_base + w_sel_addr;
          r_wdata  <= w_sel_wdata;
          r_wmask  <= w_sel_wmask;
          r_rr_ptr <= w_rr_next;
          if (w_sel_wen) begin
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_state   <= S_AW_W;
          end else begin
            r_arvalid <= 1'b1;
            r_state   <= S_AR;
          end
        end
        S_AR: if (M_AXI_ARREADY) begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b1;
          r_state   <= S_R;
        end
        S_R: if (M_AXI_RVALID) begin
          r_rready          <= 1'b0;
          r_rdata           <= M_AXI_RDATA;
          r_rvalid[r_owner] <= 1'b1;
          if (M_AXI_RRESP != 2'b00) r_err[r_owner] <= 1'b1;
          r_state           <= S_RESP;
        end
        S_AW_W: begin
          if (M_AXI_AWREADY) r_awvalid <= 1'b0;
          if (M_AXI_WREADY)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= S_B;
          end
        end
        S_B: if (M_AXI_BVALID) begin
          r_bready          <= 1'b0;
          r_rdata           <= '0;
          r_rvalid[r_owner] <= 1'b1;
          if (M_AXI_BRESP != 2'b00) r_err[r_owner] <= 1'b1;
          r_state           <= S_RESP;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_ready  = w_grant;
  assign mem_rvalid = r_rvalid;
  assign mem_rdata  = r_rdata;
  assign axi_err    = r_err;
  assign busy       = (r_state != S_IDLE);

  assign M_AXI_AWID    = r_id;
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWLEN   = 8'd0;
  assign M_AXI_AWSIZE  = 3'(SIZE);
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = 4'b0011;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWQOS   = 4'd0;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wmask;
  assign M_AXI_WLAST   = 1'b1;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARID    = r_id;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARLEN   = 8'd0;
  assign M_AXI_ARSIZE  = 3'(SIZE);
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = 4'b0011;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARQOS   = 4'd0;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

  // Single-beat, single-outstanding: IDs and RLAST carry no information.
  logic w_unused_ok;
  assign w_unused_ok = ^{M_AXI_BID, M_AXI_RID, M_AXI_RLAST};

endmodule
